// File: rtl/l2_mem_sched.sv
// L2 local memory access scheduler: invalidate sweep after reset/flush, then two-way arbitration.
// Define L2_SCHED_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module l2_mem_sched #(
  parameter int unsigned SETS     = 512,
  parameter int unsigned SET_BITS = 9,
  parameter int unsigned WAY_BITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2:0]          req_op0,
  input  logic [2:0]          req_op1,
  input  logic [SET_BITS-1:0] req_set0,
  input  logic [SET_BITS-1:0] req_set1,
  input  logic [WAY_BITS-1:0] req_way0,
  input  logic [WAY_BITS-1:0] req_way1,
  input  logic                flush_req,
  output logic                mem_rd_en,
  output logic                mem_wr_en_line,
  output logic                mem_wr_en_state,
  output logic                mem_wr_en_evict_way,
  output logic                mem_wr_en_put_reqs,
  output logic                mem_wr_rst,
  output logic [SET_BITS-1:0] mem_set,
  output logic [WAY_BITS-1:0] mem_way,
  output logic                mem_sel,
  output logic                rsp_valid,
  output logic                rsp_id,
  output logic                init_done,
  output logic                err_illegal_op
);

  typedef enum logic [1:0] {StHold, StInit, StRun} state_e;

  localparam logic [2:0] OpRead        = 3'd0;
  localparam logic [2:0] OpWrLine      = 3'd1;
  localparam logic [2:0] OpWrState     = 3'd2;
  localparam logic [2:0] OpWrEvict     = 3'd3;
  localparam logic [2:0] OpWrPutreq    = 3'd4;
  localparam logic [2:0] OpWrLineState = 3'd5;

  state_e              state_q, state_d;
  logic [SET_BITS-1:0] cnt_q, cnt_d;
  logic                ptr_q, ptr_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_id_q, rsp_id_d;
  logic                err_q, err_d;

  logic       gnt_any;
  logic       gnt_id;
  logic [2:0] gnt_op;
  logic       gnt_illegal;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StHold;
      cnt_q       <= '0;
      ptr_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      err_q       <= err_d;
    end
  end

  // Arbitration; a flush request blocks every grant in its cycle
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = 1'b0;
    if (state_q == StRun && !flush_req && (req_valid != 2'b00)) begin
      gnt_any = 1'b1;
`ifdef L2_SCHED_FIXED_PRIO_EN
      gnt_id  = !req_valid[0];
`else
      gnt_id  = (req_valid == 2'b11) ? ptr_q : req_valid[1];
`endif
    end
  end

  assign gnt_op      = gnt_id ? req_op1 : req_op0;
  assign gnt_illegal = gnt_op[2] & gnt_op[1];

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
`ifdef L2_SCHED_FIXED_PRIO_EN
    ptr_d       = ptr_q;
`else
    ptr_d       = gnt_any ? !gnt_id : ptr_q;
`endif
    rsp_valid_d = gnt_any && (gnt_op == OpRead);
    rsp_id_d    = gnt_any ? gnt_id : rsp_id_q;
    err_d       = err_q | (gnt_any & gnt_illegal);
    unique case (state_q)
      StHold: begin
        state_d = StInit;
        cnt_d   = '0;
      end
      StInit: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SET_BITS'(SETS - 1)) state_d = StRun;
      end
      StRun: begin
        if (flush_req) begin
          state_d = StInit;
          cnt_d   = '0;
        end
      end
      default: state_d = StHold;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready           = 2'b00;
    mem_rd_en           = 1'b0;
    mem_wr_en_line      = 1'b0;
    mem_wr_en_state     = 1'b0;
    mem_wr_en_evict_way = 1'b0;
    mem_wr_en_put_reqs  = 1'b0;
    mem_wr_rst          = 1'b0;
    mem_set             = '0;
    mem_way             = '0;
    mem_sel             = 1'b0;
    if (state_q == StInit) begin
      mem_rd_en  = 1'b1;
      mem_wr_rst = 1'b1;
      mem_set    = cnt_q;
    end else if (gnt_any) begin
      req_ready = gnt_id ? 2'b10 : 2'b01;
      mem_sel   = gnt_id;
      mem_set   = gnt_id ? req_set1 : req_set0;
      mem_way   = gnt_id ? req_way1 : req_way0;
      // Illegal ops are consumed without touching the array
      if (!gnt_illegal) begin
        mem_rd_en = 1'b1;
        case (gnt_op)
          OpWrLine:      mem_wr_en_line = 1'b1;
          OpWrState:     mem_wr_en_state = 1'b1;
          OpWrEvict:     mem_wr_en_evict_way = 1'b1;
          OpWrPutreq:    mem_wr_en_put_reqs = 1'b1;
          OpWrLineState: begin
            mem_wr_en_line  = 1'b1;
            mem_wr_en_state = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign rsp_valid      = rsp_valid_q;
  assign rsp_id         = rsp_id_q;
  assign init_done      = (state_q == StRun);
  assign err_illegal_op = err_q;

endmodule

// File: doc/l2_mem_sched.md
# l2_mem_sched

Access scheduler and initialiser for the L2 local memory array (tag/state/hprot, line and evict-way storage). After reset, and on a flush request, it sweeps every set with the memory's reset write so that all ways are invalid. In normal operation it arbitrates between two requesters, the request path (id 0) and the forward/eviction path (id 1), for the single-ported memory. It drives the memory control pins and tags each read response with the requester id.

## Interface
- `SETS`, 512: number of L2 sets; power of two.
- `SET_BITS`, 9: log2(SETS).
- `WAY_BITS`, 3: way index width.

- `clk`  in  1  clock
- `rst`  in  1  asynchronous reset, active-high
- `req_valid`  in  2  per-requester request valid; bit n = requester n
- `req_ready`  out  2  per-requester accept; transfer when valid & ready
- `req_op0`, `req_op1`  in  3  op code: 0 READ, 1 WR_LINE, 2 WR_STATE, 3 WR_EVICT, 4 WR_PUTREQ, 5 WR_LINE_STATE, 6/7 illegal
- `req_set0`, `req_set1`  in  SET_BITS  target set
- `req_way0`, `req_way1`  in  WAY_BITS  target way
- `flush_req`  in  1  re-run the invalidate sweep
- `mem_rd_en`  out  1  memory chip enable
- `mem_wr_en_line`, `mem_wr_en_state`, `mem_wr_en_evict_way`, `mem_wr_en_put_reqs`, `mem_wr_rst`  out  1 each  memory write strobes
- `mem_set`  out  SET_BITS  memory set_in
- `mem_way`  out  WAY_BITS  memory way
- `mem_sel`  out  1  id of the granted requester; steers the external write-data mux
- `rsp_valid`  out  1  read data valid on the memory outputs this cycle
- `rsp_id`  out  1  requester owning the response
- `init_done`  out  1  sweep complete, scheduler accepting
- `err_illegal_op`  out  1  sticky illegal-op flag

## Operation
- FSM states: HOLD, INIT, RUN.
  - HOLD is the reset state. It lasts 1 cycle, then goes to INIT.
  - INIT:
    - Set counter `cnt` starts at 0.
    - Each cycle drives `mem_rd_en=1`, `mem_wr_rst=1`, `mem_set=cnt`, `mem_way=0`, and increments `cnt`.
    - After the cycle with `cnt==SETS-1`: go to RUN and set `init_done=1`.
  - RUN: arbitrates requests.
- While in HOLD or INIT:
  - `req_ready=0`, `init_done=0`, `rsp_valid=0`.
  - `flush_req` is ignored.
- RUN arbitration:
  - At most one grant per cycle. The granted requester gets `req_ready[n]=1`.
  - `req_ready` depends combinationally on `req_valid`, the state and the priority pointer.
  - The non-granted requester sees ready=0 and must hold its request.
- On grant, the same cycle (combinational):
  - `mem_sel=n`, `mem_set=req_setn`, `mem_way=req_wayn`, `mem_rd_en=1`.
  - Strobes by op:
    - READ: no strobe.
    - WR_LINE: line.
    - WR_STATE: state.
    - WR_EVICT: evict_way.
    - WR_PUTREQ: put_reqs.
    - WR_LINE_STATE: line and state.
  - Illegal op: the request is accepted, `mem_rd_en=0`, no strobes, and `err_illegal_op` is set. The flag clears only on reset.
- With no grant, all mem controls are 0 and `mem_set`/`mem_way`/`mem_sel` are 0.
- Round-robin: a 1-bit pointer names the preferred requester. After any grant the pointer moves to the other id. Pointer reset value is 0.
- Flush: `flush_req=1` in RUN suppresses all grants that cycle. Next state is INIT with `cnt=0` and `init_done` cleared. A read granted the previous cycle still produces its response.

## Timing
- Write accepted at edge T: the memory updates at edge T.
- READ accepted in cycle T: `rsp_valid=1` and `rsp_id=n` in cycle T+1, aligned with the memory read data.
  - Back-to-back reads produce back-to-back responses.
  - `rsp_valid` and `rsp_id` are registered.
- Sweep occupies exactly SETS cycles. The first grant is possible SETS+1 cycles after `rst` deasserts.
- Reset values: `req_ready=0`, every `mem_*` output 0, `rsp_valid=0`, `rsp_id=0`, `init_done=0`, `err_illegal_op=0`, `cnt=0`, pointer 0, state HOLD.
- Reset asserted mid-sweep or mid-RUN: everything returns to the reset values immediately (asynchronous). A pending `rsp_valid` is dropped. After release the sweep restarts from set 0.

## Configuration
- `L2_SCHED_FIXED_PRIO_EN`:
  - Defined: requester 0 always wins when both are valid, and the pointer is unused.
  - Undefined: round-robin as described above.

## Test plan
- Reset release with SETS=512: `mem_wr_rst=1` for exactly 512 consecutive cycles with `mem_set` 0..511. `init_done` rises the following cycle, with no `req_ready` before it.
- Both requesters continuously valid with READs (round-robin): grants alternate 0,1,0,1. `rsp_id` follows the same sequence one cycle later, with `rsp_valid` high every cycle.
- Requester 1 WR_LINE_STATE to set 0x1A5, way 6: same cycle `mem_wr_en_line=mem_wr_en_state=1`, `mem_set=0x1A5`, `mem_way=6`, `mem_sel=1`. A following READ of the same set returns the written data at T+1.
- `flush_req` pulsed in the cycle after a READ grant: the response still appears. `init_done` drops and a 512-cycle sweep runs. Requests stalled throughout resume after it.
- `req_op0=7`: `req_ready[0]=1`, no strobes, `mem_rd_en=0`, `err_illegal_op=1` and sticky until `rst`.
- `rst` asserted at sweep set 200: outputs zero immediately. After release the sweep restarts at set 0 and runs 512 cycles.
